// File: rtl/prog_mem_loader.sv
// Serial program loader: assembles framed bytes into 32-bit little-endian
// words and writes them into the Nios II program memory, holding the CPU
// in reset while a frame is in flight.
module prog_mem_loader #(
  parameter int          ADDR_W    = 15,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              cpu_reset_req,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;   // byte position within header or word
  logic [15:0] addr_q, addr_d;   // kept 16 bits wide; truncation gives the wrap
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] word_q, word_d;
  logic        crr_q, crr_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        xfer;

  assign xfer = rx_valid & rx_ready;

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= 2'd0;
      addr_q  <= 16'd0;
      cnt_q   <= 16'd0;
      idx_q   <= 16'd0;
      sum_q   <= 8'd0;
      word_q  <= 32'd0;
      crr_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      word_q  <= word_d;
      crr_q   <= crr_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: frame parsing, word assembly and checksum accumulation
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    word_d  = word_q;
    crr_d   = crr_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer && rx_data == SYNC_BYTE) begin
          state_d = S_HDR;
          bcnt_d  = 2'd0;
          sum_d   = 8'd0;
          idx_d   = 16'd0;
          crr_d   = 1'b1;
        end
      end
      S_HDR: begin
        if (xfer) begin
          sum_d  = sum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: addr_d[7:0]  = rx_data;
            2'd1: addr_d[15:8] = rx_data;
            2'd2: cnt_d[7:0]   = rx_data;
            default: begin
              cnt_d[15:8] = rx_data;
              // An empty frame goes straight to the checksum byte
              state_d = ({rx_data, cnt_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
            end
          endcase
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d  = sum_q + rx_data;
          // Shift right so the first byte ends up in bits [7:0]
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        addr_d  = addr_q + 16'd1;
        state_d = (idx_q + 16'd1 == cnt_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = S_IDLE;
          if (rx_data == sum_q) begin
            ok_d  = 1'b1;
            crr_d = 1'b0;
          end else begin
            // CPU stays held: a corrupt image must never run
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_ready       = (state_q != S_WRITE);
  assign mem_write      = (state_q == S_WRITE);
  assign mem_chipselect = mem_write;
  assign mem_byteenable = {4{mem_write}};
  assign mem_address    = addr_q[ADDR_W-1:0];
  assign mem_writedata  = word_q;
  assign cpu_reset_req  = crr_q;
  assign busy           = (state_q != S_IDLE);
  assign load_ok        = ok_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: streams hand-built frames and checks
// memory writes, status pulses and CPU reset hold against fixed expectations.
module tb_prog_mem_loader;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              cpu_reset_req;
  logic              busy;
  logic              load_ok;
  logic              load_err;

  int n_tests = 0;
  int n_fail  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;
  int log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0] fr[$];

  prog_mem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .cpu_reset_req  (cpu_reset_req),
    .busy           (busy),
    .load_ok        (load_ok),
    .load_err       (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory-side monitor: logs writes and checks strobe consistency
  always @(negedge clk) begin
    if (mem_write || mem_chipselect || mem_byteenable != 4'h0) begin
      chk("wr_cs", {31'd0, mem_chipselect}, {31'd0, mem_write});
      chk("wr_be", {28'd0, mem_byteenable}, mem_write ? 32'hF : 32'h0);
      chk("wr_rdy", {31'd0, rx_ready}, 32'd0);
      if (mem_write) begin
        log_addr.push_back(int'(mem_address));
        log_data.push_back(mem_writedata);
      end
    end
    if (load_ok) ok_cnt++;
    if (load_err) err_cnt++;
    if (load_ok && load_err) chk("ok_err_both", 32'd1, 32'd0);
  end

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waits;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waits = 0;
    while (!rx_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) chk("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    ok_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic load_basic(input logic [7:0] csum);
    fr = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, csum};
  endtask

  // Sends fr; checks busy/cpu hold after sync and the status cycle after CSUM
  task automatic send_frame(input string tag, input bit gaps, input bit good);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], gaps);
      if (i == 0) begin
        chk({tag, "_busy_sync"}, {31'd0, busy}, 32'd1);
        chk({tag, "_crr_sync"}, {31'd0, cpu_reset_req}, 32'd1);
      end
    end
    chk({tag, "_ok"}, {31'd0, load_ok}, {31'd0, good});
    chk({tag, "_err"}, {31'd0, load_err}, {31'd0, !good});
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_crr_end"}, {31'd0, cpu_reset_req}, {31'd0, !good});
    @(negedge clk);
    chk({tag, "_pulse_w"}, {31'd0, load_ok | load_err}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_wr"}, {29'd0, mem_write, mem_chipselect, busy}, 32'd0);
    chk({tag, "_be"}, {28'd0, mem_byteenable}, 32'd0);
    chk({tag, "_addr"}, {17'd0, mem_address}, 32'd0);
    chk({tag, "_data"}, mem_writedata, 32'd0);
    chk({tag, "_stat"}, {29'd0, cpu_reset_req, load_ok, load_err}, 32'd0);
  endtask

  task automatic check_basic_writes(input string tag);
    chk({tag, "_nwr"}, log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      chk({tag, "_a0"}, log_addr[0], 32'h0010);
      chk({tag, "_d0"}, log_data[0], 32'h44332211);
      chk({tag, "_a1"}, log_addr[1], 32'h0011);
      chk({tag, "_d1"}, log_data[1], 32'h88776655);
    end
  endtask

  initial begin
    // Reset values
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame
    clear_log();
    load_basic(8'h76);
    send_frame("basic", 1'b0, 1'b1);
    check_basic_writes("basic");
    chk("basic_okcnt", ok_cnt, 32'd1);
    chk("basic_errcnt", err_cnt, 32'd0);

    // Address wrap-around
    clear_log();
    fr = '{8'hA5, 8'hFF, 8'h7F, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    send_frame("wrap", 1'b0, 1'b1);
    chk("wrap_nwr", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      chk("wrap_a0", log_addr[0], 32'h7FFF);
      chk("wrap_d0", log_data[0], 32'h0);
      chk("wrap_a1", log_addr[1], 32'h0000);
      chk("wrap_d1", log_data[1], 32'h0);
    end

    // Leading garbage then empty frame
    clear_log();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h3C, 1'b0);
    chk("garb_busy", {31'd0, busy}, 32'd0);
    chk("garb_crr", {31'd0, cpu_reset_req}, 32'd0);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame("empty", 1'b0, 1'b1);
    chk("empty_nwr", log_addr.size(), 32'd0);
    chk("empty_okcnt", ok_cnt, 32'd1);

    // Bad checksum, then recovery
    clear_log();
    load_basic(8'h77);
    send_frame("bad", 1'b0, 1'b0);
    check_basic_writes("bad");
    chk("bad_errcnt", err_cnt, 32'd1);
    chk("bad_okcnt", ok_cnt, 32'd0);
    repeat (3) @(negedge clk);
    chk("bad_crr_hold", {31'd0, cpu_reset_req}, 32'd1);
    clear_log();
    load_basic(8'h76);
    send_frame("recov", 1'b0, 1'b1);
    check_basic_writes("recov");

    // Valid gaps
    clear_log();
    load_basic(8'h76);
    send_frame("gaps", 1'b1, 1'b1);
    check_basic_writes("gaps");
    chk("gaps_okcnt", ok_cnt, 32'd1);

    // Reset after the 6th payload byte
    clear_log();
    load_basic(8'h76);
    for (int i = 0; i < 11; i++) send_byte(fr[i], 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    chk("midrst_nwr", log_addr.size(), 32'd1);
    if (log_addr.size() == 1) chk("midrst_a0", log_addr[0], 32'h0010);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_log();
    send_frame("after", 1'b0, 1'b1);
    check_basic_writes("after");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Serial program loader that sits directly upstream of the Nios II on-chip program memory. It accepts a framed byte stream with a valid/ready handshake and assembles little-endian 32-bit words. Each word goes out as a single-cycle write on the memory's native slave port (address, byteenable, chipselect, write, writedata). While a frame is in flight, the block holds the CPU in reset through `cpu_reset_req`, and it reports frame status.

## Interface
- `ADDR_W`, default 15: word-address width of the program memory (32768 words).
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` in 1: system clock; the single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: block can accept a byte; a byte transfers on a rising edge with `rx_valid & rx_ready`.
- `mem_address` out ADDR_W: word address to the memory.
- `mem_byteenable` out 4: constant 4'hF while `mem_write` is high; 4'h0 otherwise.
- `mem_chipselect` out 1: high only together with `mem_write`.
- `mem_write` out 1: one-cycle write strobe.
- `mem_writedata` out 32: assembled word.
- `cpu_reset_req` out 1: holds the CPU and the program-memory clock-enable gating in reset while loading.
- `busy` out 1: a frame is in progress (sync byte seen, checksum not yet processed).
- `load_ok` out 1: one-cycle pulse; frame completed with a good checksum.
- `load_err` out 1: one-cycle pulse; frame completed with a bad checksum.

## Operation
- Frame format, in byte order:
  - `SYNC_BYTE`.
  - `ADDR_LO`, `ADDR_HI`: start word address, 16 bits. Bits above `ADDR_W` are ignored.
  - `CNT_LO`, `CNT_HI`: word count N, 16 bits.
  - 4·N payload bytes, little-endian per word. The first byte goes to `writedata[7:0]`.
  - `CSUM`.
- Checksum rule:
  - `CSUM` must equal the sum modulo 256 of every byte from `ADDR_LO` through the last payload byte.
  - `SYNC_BYTE` and `CSUM` are excluded from the sum.
- States:
  - IDLE: bytes other than `SYNC_BYTE` are accepted and discarded. `SYNC_BYTE` moves to HDR.
  - HDR: accepts 4 bytes. After `CNT_HI`, go to CSUM if N=0, otherwise to DATA.
  - DATA: accepts 4 bytes into the word shift register. After the 4th byte, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - Drives `mem_write` = `mem_chipselect` = 1 with `mem_address` = start + word index.
    - `rx_ready` = 0 during this cycle.
    - Then increments the word index and address. Go to CSUM if index = N, else back to DATA.
  - CSUM: accepts one byte, compares it, pulses `load_ok` or `load_err`, then returns to IDLE.
- In IDLE, HDR, DATA and CSUM, `rx_ready` = 1.
- Address arithmetic is modulo 2^ADDR_W: writing past 0x7FFF wraps to 0x0000. N is not checked against memory depth.
- `cpu_reset_req`:
  - Set on the edge that accepts `SYNC_BYTE`.
  - Cleared on the edge that accepts a good `CSUM`.
  - On a bad `CSUM` it stays set until a later frame completes good, so a corrupt image never runs.
- `SYNC_BYTE` inside HDR, DATA or CSUM is ordinary data; there is no resynchronisation.
- Memory writes are not rolled back on checksum failure.

## Timing
- Reset values:
  - `rx_ready` = 1 (IDLE).
  - `mem_write` = `mem_chipselect` = 0, `mem_byteenable` = 0.
  - `mem_address` = 0, `mem_writedata` = 0.
  - `cpu_reset_req` = 0, `busy` = 0, `load_ok` = `load_err` = 0.
- Reset mid-frame: return to IDLE immediately and asynchronously with all reset values. Words already written stay in memory. `cpu_reset_req` drops.
- Write latency: if the 4th payload byte is accepted at edge k, then `mem_write` is high for the cycle between edges k and k+1. `mem_address` and `mem_writedata` are stable for that whole cycle. The memory captures the write at edge k+1.
- Minimum frame length is 6+5·N cycles with `rx_valid` held high. Each word costs 4 byte cycles plus 1 WRITE cycle.
- `busy` goes high the cycle after `SYNC_BYTE` is accepted. It goes low the cycle after `CSUM` is accepted, coincident with the status pulse.
- `load_ok` and `load_err` are registered pulses, exactly one cycle wide, in the cycle after `CSUM` is accepted. They are never both high.
- `rx_valid` may drop at any byte boundary; state is held indefinitely. There is no timeout.

## Test plan
- Basic frame: stream A5 10 00 02 00 11 22 33 44 55 66 77 88 76 -> two writes:
  - addr 0x0010, data 0x44332211, be 0xF.
  - addr 0x0011, data 0x88776655.
  - Then one `load_ok` pulse; `cpu_reset_req` 1→0; no `load_err`.
- Wrap-around: A5 FF 7F 02 00 + 8 zero bytes + 80 -> writes at 0x7FFF then 0x0000, each data 0; then `load_ok`.
- Empty frame and leading garbage:
  - 00 FF 3C before A5 00 00 00 00 00 -> garbage ignored; no `mem_write`; `load_ok` pulses.
  - `cpu_reset_req` pulses high for the frame only.
- Bad checksum then recovery:
  - Basic frame with CSUM 77 -> both writes occur; `load_err` pulses; `cpu_reset_req` stays 1.
  - Then the correct basic frame -> `load_ok`; `cpu_reset_req` 0.
- Backpressure and gaps:
  - Random `rx_valid` gaps in the basic frame -> identical writes.
  - `rx_ready` is low exactly in each WRITE cycle, and no byte is lost or duplicated there.
- Reset mid-frame: assert `reset_n` = 0 after the 6th payload byte of the basic frame -> all outputs at reset values within the reset assertion.
  - Exactly one write, to addr 0x0010, has occurred.
  - A following complete basic frame loads correctly.
